// File: rtl/tracer_buf_pkg.sv
// Shared constants and types for the tracer-buffer BRAM port arbiter.
package tracer_buf_pkg;

  localparam int BUF_BYTE_SHIFT = 2;
  localparam int TRACER_ADDR_W  = 11;

  localparam int REQ_LOADER = 0;
  localparam int REQ_CORE   = 1;
  localparam int REQ_PS     = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/tracer_buf_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the pointer.
module tracer_buf_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j     = 0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_valid[j]) begin
        o_any    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/tracer_buf_arbiter.sv
// Round-robin arbiter with burst lock sharing one tracer-buffer BRAM port;
// read data is steered back to the issuing requester by a one-hot tag pipeline.
module tracer_buf_arbiter
  import tracer_buf_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = TRACER_ADDR_W,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int LOCK_MAX   = 0
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      tracer_buf_en,
  output logic [3:0]                tracer_buf_we,
  output logic [31:0]               tracer_buf_addr,
  output logic [31:0]               tracer_buf_dout,
  input  logic [31:0]               tracer_buf_din
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 16;

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_owner, w_owner_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_lock_cnt, w_cnt_nxt;

  logic [NUM_REQ-1:0]   w_pick_gnt;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;

  logic [NUM_REQ-1:0]   w_gnt;
  logic [IDX_W-1:0]     w_idx;
  logic                 w_xfer;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [DATA_W-1:0]    w_sel_wdata;

  logic                 r_en;
  logic [3:0]           r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_dout;
  logic [NUM_REQ-1:0]   r_tag [0:RD_LATENCY];
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_data;

  function automatic logic [IDX_W-1:0] f_next_ptr(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  tracer_buf_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_lock_cnt;
    w_gnt       = '0;
    w_idx       = w_pick_idx;
    case (r_state)
      ST_IDLE: begin
        w_gnt = w_pick_gnt;
        if (w_pick_any) begin
          w_ptr_nxt = f_next_ptr(w_pick_idx);
          // A lock limit of one beat means the lock can never outlive its first beat.
          if (req_lock[w_pick_idx] && (LOCK_MAX != 1)) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_pick_idx;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        w_idx          = r_owner;
        w_gnt[r_owner] = req_valid[r_owner];
        if (req_valid[r_owner]) w_cnt_nxt = r_lock_cnt + 1'b1;
        if (!req_lock[r_owner]) begin
          w_state_nxt = ST_IDLE;
        end else if ((LOCK_MAX > 0) && req_valid[r_owner] &&
                     (w_cnt_nxt == CNT_W'(LOCK_MAX))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_xfer      = |w_gnt;
    w_sel_we    = req_we[w_idx];
    w_sel_addr  = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
    w_sel_wdata = req_wdata[int'(w_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_cnt <= w_cnt_nxt;
    end
  end

  // Port stage: the granted beat is presented to the BRAM one cycle after the grant.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_en   <= 1'b0;
      r_we   <= 4'h0;
      r_addr <= '0;
      r_dout <= '0;
    end else if (w_xfer) begin
      r_en   <= 1'b1;
      r_we   <= w_sel_we ? 4'hF : 4'h0;
      r_addr <= w_sel_addr;
      r_dout <= w_sel_wdata;
    end else begin
      r_en   <= 1'b0;
      r_we   <= 4'h0;
    end
  end

  // Tag stage k is aligned with BRAM cycle k after enable; the last stage marks valid din.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      for (int k = 0; k <= RD_LATENCY; k++) r_tag[k] <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_tag[0] <= (w_xfer && !w_sel_we) ? w_gnt : '0;
      for (int k = 1; k <= RD_LATENCY; k++) r_tag[k] <= r_tag[k-1];
      r_rsp_valid <= r_tag[RD_LATENCY];
      if (|r_tag[RD_LATENCY]) r_rsp_data <= tracer_buf_din[DATA_W-1:0];
    end
  end

  assign req_gnt         = w_gnt & {NUM_REQ{s_axi_aresetn}};
  assign rsp_valid       = r_rsp_valid;
  assign rsp_data        = r_rsp_data;
  assign tracer_buf_en   = r_en;
  assign tracer_buf_we   = r_we;
  assign tracer_buf_addr = {{(32-ADDR_W-BUF_BYTE_SHIFT){1'b0}}, r_addr, {BUF_BYTE_SHIFT{1'b0}}};
  assign tracer_buf_dout = r_dout;

endmodule

// File: tb/tb_tracer_buf_arbiter.sv
// Directed bench for tracer_buf_arbiter: rotation, lock, lock limit, writes, mid-flight reset.
module tb_tracer_buf_arbiter;
  import tracer_buf_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  valid, lock, we;
  logic [32:0] addr;
  logic [95:0] wdata;
  logic [2:0]  gnt, rspv;
  logic [31:0] rspd;
  logic        en;
  logic [3:0]  bwe;
  logic [31:0] baddr, bdout, bdin;

  logic [2:0]  v4, l4;
  logic [2:0]  gnt4, rspv4;
  logic [31:0] rspd4, baddr4, bdout4;
  logic        en4;
  logic [3:0]  bwe4;

  int n_chk = 0;
  int n_err = 0;

  tracer_buf_arbiter #(.NUM_REQ(3), .ADDR_W(11), .DATA_W(32), .RD_LATENCY(1), .LOCK_MAX(0)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .req_valid(valid), .req_lock(lock), .req_we(we), .req_addr(addr), .req_wdata(wdata),
    .req_gnt(gnt), .rsp_valid(rspv), .rsp_data(rspd),
    .tracer_buf_en(en), .tracer_buf_we(bwe), .tracer_buf_addr(baddr),
    .tracer_buf_dout(bdout), .tracer_buf_din(bdin)
  );

  tracer_buf_arbiter #(.NUM_REQ(3), .ADDR_W(11), .DATA_W(32), .RD_LATENCY(1), .LOCK_MAX(4)) dut4 (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .req_valid(v4), .req_lock(l4), .req_we(3'b000), .req_addr(33'd0), .req_wdata(96'd0),
    .req_gnt(gnt4), .rsp_valid(rspv4), .rsp_data(rspd4),
    .tracer_buf_en(en4), .tracer_buf_we(bwe4), .tracer_buf_addr(baddr4),
    .tracer_buf_dout(bdout4), .tracer_buf_din(32'd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f_word(input logic [10:0] w);
    return 32'hC0DE_0000 ^ {18'd0, w, 3'b101};
  endfunction

  // BRAM model with one cycle read latency; contents are a fixed function of the address.
  always @(posedge clk) begin
    if (en) bdin <= f_word(baddr[12:2]);
  end

  typedef struct {
    logic [2:0] v;
    logic [2:0] l;
    logic [2:0] g;
    logic       e;
    logic [2:0] rv;
  } vec_t;

  vec_t rr_tbl [10];
  vec_t bub_tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t t, input string nm);
    valid = t.v;
    lock  = t.l;
    @(negedge clk);
    chk({nm, "_gnt"}, {29'd0, gnt}, {29'd0, t.g});
    chk({nm, "_en"},  {31'd0, en},  {31'd0, t.e});
    chk({nm, "_rsp"}, {29'd0, rspv}, {29'd0, t.rv});
    for (int j = 0; j < 3; j++)
      if (t.rv[j]) chk({nm, "_data"}, rspd, f_word(addr[j*11 +: 11]));
    next_cycle();
  endtask

  initial begin
    int bad;
    bdin  = 32'd0;
    rst_n = 1'b0;
    valid = 3'b111;
    lock  = 3'b000;
    we    = 3'b000;
    v4    = 3'b000;
    l4    = 3'b000;
    addr  = {11'd114, 11'd107, 11'd100};
    wdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

    rr_tbl[0] = '{3'b111, 3'b000, 3'b001, 1'b0, 3'b000};
    rr_tbl[1] = '{3'b111, 3'b000, 3'b010, 1'b1, 3'b000};
    rr_tbl[2] = '{3'b111, 3'b000, 3'b100, 1'b1, 3'b000};
    rr_tbl[3] = '{3'b111, 3'b000, 3'b001, 1'b1, 3'b001};
    rr_tbl[4] = '{3'b111, 3'b000, 3'b010, 1'b1, 3'b010};
    rr_tbl[5] = '{3'b111, 3'b000, 3'b100, 1'b1, 3'b100};
    rr_tbl[6] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b001};
    rr_tbl[7] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b010};
    rr_tbl[8] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b100};
    rr_tbl[9] = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000};

    bub_tbl[0] = '{3'b011, 3'b001, 3'b001, 1'b0, 3'b000};
    bub_tbl[1] = '{3'b010, 3'b001, 3'b000, 1'b1, 3'b000};
    bub_tbl[2] = '{3'b010, 3'b001, 3'b000, 1'b0, 3'b000};
    bub_tbl[3] = '{3'b011, 3'b000, 3'b001, 1'b0, 3'b001};
    bub_tbl[4] = '{3'b011, 3'b000, 3'b010, 1'b1, 3'b000};
    bub_tbl[5] = '{3'b000, 3'b000, 3'b000, 1'b1, 3'b000};

    // Held in reset with every requester asking.
    next_cycle();
    next_cycle();
    chk("rst_gnt",  {29'd0, gnt}, 32'd0);
    chk("rst_en",   {31'd0, en},  32'd0);
    chk("rst_rsp",  {29'd0, rspv}, 32'd0);
    chk("rst_addr", baddr, 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) run_vec(rr_tbl[k], "rr");

    // Single write by the core requester.
    valid = 3'b010;
    we    = 3'b010;
    addr[21:11]  = 11'd64;
    wdata[63:32] = 32'hA5A5_0001;
    @(negedge clk);
    chk("wr_gnt", {29'd0, gnt}, {29'd0, 3'b010});
    next_cycle();
    valid = 3'b000;
    we    = 3'b000;
    @(negedge clk);
    chk("wr_en",   {31'd0, en}, 32'd1);
    chk("wr_we",   {28'd0, bwe}, 32'h0000_000F);
    chk("wr_addr", baddr, 32'h0000_0100);
    chk("wr_dout", bdout, 32'hA5A5_0001);
    next_cycle();
    addr[21:11] = 11'd107;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rspv != 3'b000) bad++;
      next_cycle();
    end
    chk("wr_no_rsp", bad, 0);

    // Requester 0 streams 625 locked reads while requester 1 waits.
    valid = 3'b011;
    lock  = 3'b001;
    bad   = 0;
    for (int c = 0; c < 625; c++) begin
      if (c == 624) lock = 3'b000;
      @(negedge clk);
      if (gnt != 3'b001) bad++;
      if (c > 0 && en != 1'b1) bad++;
      next_cycle();
    end
    chk("lock_hold", bad, 0);
    @(negedge clk);
    chk("lock_release_gnt", {29'd0, gnt}, {29'd0, 3'b010});
    next_cycle();
    valid = 3'b000;
    for (int k = 0; k < 4; k++) next_cycle();

    for (int k = 0; k < 6; k++) run_vec(bub_tbl[k], "bubble");
    valid = 3'b000;
    lock  = 3'b000;
    for (int k = 0; k < 4; k++) next_cycle();

    // Lock limited to 4 beats on the second instance.
    v4 = 3'b101;
    l4 = 3'b001;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] exp_g;
      exp_g = (c == 4) ? 3'b100 : 3'b001;
      @(negedge clk);
      chk("lockmax_gnt", {29'd0, gnt4}, {29'd0, exp_g});
      next_cycle();
    end
    v4 = 3'b000;
    l4 = 3'b000;

    // Two reads in flight, then reset.
    valid = 3'b001;
    @(negedge clk);
    chk("mid_gnt_a", {29'd0, gnt}, {29'd0, 3'b001});
    next_cycle();
    valid = 3'b010;
    @(negedge clk);
    chk("mid_gnt_b", {29'd0, gnt}, {29'd0, 3'b010});
    next_cycle();
    rst_n = 1'b0;
    valid = 3'b111;
    #1;
    chk("mid_rst_gnt",  {29'd0, gnt}, 32'd0);
    chk("mid_rst_en",   {31'd0, en}, 32'd0);
    chk("mid_rst_addr", baddr, 32'd0);
    chk("mid_rst_dout", bdout, 32'd0);
    chk("mid_rst_data", rspd, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    valid = 3'b000;
    bad   = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rspv != 3'b000) bad++;
      next_cycle();
    end
    chk("mid_no_stale_rsp", bad, 0);
    valid = 3'b111;
    @(negedge clk);
    chk("mid_ptr_restart", {29'd0, gnt}, {29'd0, 3'b001 << REQ_LOADER});
    next_cycle();
    valid = 3'b000;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tracer_buf_arbiter.md
Name: tracer_buf_arbiter

Overview:
- Shares the single tracer-buffer BRAM port (32-bit word RAM, byte-addressed) among NUM_REQ requesters, e.g. the contour loader, the tracer core writer and the PS-side readback.
- Performs round-robin arbitration with an optional burst lock, so a streaming reader keeps the port for a whole contour pass.
- Routes read data back to the originating requester with a tagged latency pipeline.
- Sits between the CImgTracer control blocks and the BRAM controller port.

Parameters:
- NUM_REQ, 3: number of requesters; index 0 has the highest initial round-robin priority.
- ADDR_W, 11: word-address width of each requester.
- DATA_W, 32: data width.
- RD_LATENCY, 1: BRAM cycles from en to valid tracer_buf_din.
- LOCK_MAX, 0: maximum consecutive locked grants before a forced release; 0 = unlimited.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  access request per requester.
- req_lock  in  NUM_REQ  hold the grant after the current beat.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  flattened word addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- req_gnt  out  NUM_REQ  one-hot accept; a beat transfers when req_valid[i] and req_gnt[i] are both high.
- rsp_valid  out  NUM_REQ  one-hot read-data valid.
- rsp_data  out  DATA_W  read data, shared by all requesters.
- tracer_buf_en  out  1  BRAM enable.
- tracer_buf_we  out  4  BRAM byte write enables.
- tracer_buf_addr  out  32  byte address = {zeros, word_addr, 2'b00}.
- tracer_buf_dout  out  32  write data.
- tracer_buf_din  in  32  read data.

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0, lock counter 0, tag pipeline cleared. Reset mid-operation drops in-flight reads: no rsp_valid is issued for them.
- State IDLE:
  - req_gnt goes to the first requester with req_valid high, searching from the RR pointer (combinational, same cycle).
  - On a transfer by requester i: pointer <= i+1 mod NUM_REQ.
  - If req_lock[i] is also high, go to LOCKED(owner=i) with lock_cnt=1.
- State LOCKED:
  - req_gnt = req_valid[owner] only; all other requesters are stalled.
  - Each owner transfer increments lock_cnt.
  - Owner cycles with req_valid low issue no access; the lock is still held.
  - Exit to IDLE when req_lock[owner] is low in any cycle (that cycle's beat, if valid, is still granted).
  - Exit to IDLE also after a transfer that makes lock_cnt == LOCK_MAX (LOCK_MAX>0). The pointer is then already past the owner, so the others win the next round.
- Port timing:
  - A transfer at cycle T drives tracer_buf_en=1, addr, dout and we (4'hF for a write, 4'h0 for a read) registered in cycle T+1.
  - With no transfer, en=0 and we=0; addr and dout hold their values.
- Read return:
  - A 1-hot tag of the read requester is shifted through a RD_LATENCY+1 stage pipeline.
  - rsp_data is registered from tracer_buf_din, and rsp_valid[tag] is asserted at cycle T+2+RD_LATENCY for exactly one cycle.
  - Writes produce no response.
- Throughput and ordering: one beat per cycle, back-to-back, with no bubbles between different requesters. Responses return in issue order.
- req_lock without req_valid in IDLE has no effect.
- Several requesters locking at once: only the granted one becomes owner.
- A request input changing while req_gnt is low is legal; no request is latched.

Decomposition:
- Package tracer_buf_pkg:
  - BUF_BYTE_SHIFT=2
  - TRACER_ADDR_W=11
  - requester index constants REQ_LOADER=0, REQ_CORE=1, REQ_PS=2
  - state encoding ST_IDLE, ST_LOCKED
- Sub-module tracer_buf_rr_pick: combinational round-robin picker taking (valid vector, pointer) and returning (one-hot grant, index). It is reused by later arbiters.

Test Plan:
- Reset, then req_valid=3'b111, no lock, all reads → grants rotate 0,1,2,0 on successive cycles; tracer_buf_en continuous from cycle 1; rsp_valid one-hot follows the same order 3 cycles after each grant (RD_LATENCY=1).
- Requester 0 locked for 625 reads while requester 1 requests → req_gnt[1]=0 for all 625 beats; requester 1 is granted the cycle after req_lock[0] drops.
- LOCK_MAX=4, requester 0 lock held, requester 2 requesting → 4 beats to requester 0, then 1 beat to requester 2, then requester 0 is re-granted.
- Write by requester 1 at addr 11'd64, data 32'hA5A5_0001 → next cycle en=1, we=4'hF, tracer_buf_addr=32'h100, dout=32'hA5A5_0001; no rsp_valid.
- Owner drops req_valid for 2 cycles under lock → en=0 for those 2 cycles; other requesters remain stalled.
- Assert s_axi_aresetn=0 with 2 reads in flight → all outputs 0 immediately; after release no stale rsp_valid appears; the pointer restarts at 0.
